mips_muldiv_unit: RTL and testbench

//   Parametrised iterative multiply/divide unit for the 5-stage MIPS pipeline.

---
 rtl/mips_muldiv_unit_if.sv | 28 ++
 rtl/mips_muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_unit_if.sv
// Handshake/data bundle between the EX stage and the iterative mul/div unit.
// The EX stage drives the master side; the unit is the slave.
interface mips_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, srca, srcb, hi_we, lo_we, wdata,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, srca, srcb, hi_we, lo_we, wdata,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO, one result bit per cycle.
// Operates on magnitudes; signs are reapplied in a single FIN cycle.
module mips_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic                clk,
  input logic                reset,
  mips_muldiv_unit_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q;
  logic               neg_q;
  logic               neg_rem_q;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic               div_zero_q;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] acc_step, prod;
  logic [WIDTH-1:0]   quot, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (count_q == LastCnt) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy     = (state_q != StIdle);
    bus.done     = done_q;
    bus.div_zero = div_zero_q;
    bus.hi       = hi_q;
    bus.lo       = lo_q;
  end

  // Operand magnitudes; op[0] selects the signed variants.
  always_comb begin
    a_neg = bus.op[0] & bus.srca[WIDTH-1];
    b_neg = bus.op[0] & bus.srcb[WIDTH-1];
    a_mag = a_neg ? -bus.srca : bus.srca;
    b_mag = b_neg ? -bus.srcb : bus.srcb;
  end

  // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    if (is_div_q) begin
      acc_step = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Sign correction; a zero divisor leaves the remainder equal to the dividend.
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quot = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      res_lo = dz_q ? {WIDTH{1'b1}} : (neg_q ? -quot : quot);
      res_hi = neg_rem_q ? -rem : rem;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            count_q    <= '0;
            is_div_q   <= bus.op[1];
            neg_q      <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            dz_q       <= bus.op[1] & (bus.srcb == '0);
            div_zero_q <= 1'b0;
            opnd_q     <= bus.op[1] ? b_mag : a_mag;
            acc_q      <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        StRun: begin
          acc_q   <= acc_step;
          count_q <= count_q + CW'(1);
        end
        StFin: begin
          hi_q       <= res_hi;
          lo_q       <= res_lo;
          done_q     <= 1'b1;
          div_zero_q <= dz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit (WIDTH=32): model results queued at issue,
// popped and compared when done pulses.
module tb_mips_muldiv_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mips_muldiv_unit_if #(.WIDTH(32)) bus ();

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic exp_t model(input string name, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    logic signed [63:0] sa64, sb64;
    logic signed [31:0] sa32, sb32;
    e.name = name;
    e.dz   = 1'b0;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    sa32 = a;
    sb32 = b;
    case (op)
      2'd0: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd1: begin p = sa64 * sb64; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1;
        end else if (op == 2'd2) begin
          e.lo = a / b; e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = 32'd0;
        end else begin
          e.lo = sa32 / sb32; e.hi = sa32 % sb32;
        end
      end
    endcase
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic we_hi, input logic we_lo);
    logic [31:0] prev_hi, prev_lo;
    prev_hi = bus.hi;
    prev_lo = bus.lo;
    bus.start = 1'b1; bus.op = op; bus.srca = a; bus.srcb = b;
    bus.hi_we = we_hi; bus.lo_we = we_lo; bus.wdata = 32'hDEAD_BEEF;
    sb.push_back(model(name, op, a, b));
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.srca = $urandom; bus.srcb = $urandom; bus.op = 2'($urandom_range(0, 3));
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++; $display("FAIL %s busy after start: got %b want 1", name, bus.busy);
    end
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++; $display("FAIL %s done after start: got %b want 0", name, bus.done);
    end
    vectors++;
    if (bus.hi !== prev_hi || bus.lo !== prev_lo) begin
      miscompares++;
      $display("FAIL %s hi/lo hold: got %h/%h want %h/%h", name, bus.hi, bus.lo, prev_hi,
               prev_lo);
    end
    vectors++;
    if (bus.div_zero !== 1'b0) begin
      miscompares++; $display("FAIL %s div_zero clear on start: got %b want 0", name,
                              bus.div_zero);
    end
  endtask

  task automatic wait_result(input int elapsed);
    exp_t e;
    int   n;
    bit   got;
    n = elapsed;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      got = bus.done;
    end
    vectors++;
    if (!got || n != 33) begin
      miscompares++; $display("FAIL latency: done after %0d edges (seen %0b), want 33", n, got);
    end
    if (sb.size() == 0) begin
      miscompares++; $display("FAIL scoreboard: empty queue, want an entry");
      return;
    end
    e = sb.pop_front();
    vectors++;
    if (bus.hi !== e.hi) begin
      miscompares++; $display("FAIL %s hi: got %h want %h", e.name, bus.hi, e.hi);
    end
    vectors++;
    if (bus.lo !== e.lo) begin
      miscompares++; $display("FAIL %s lo: got %h want %h", e.name, bus.lo, e.lo);
    end
    vectors++;
    if (bus.div_zero !== e.dz) begin
      miscompares++; $display("FAIL %s div_zero: got %b want %b", e.name, bus.div_zero, e.dz);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL %s busy at done: got %b want 0", e.name, bus.busy);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 2'd0; bus.srca = '0; bus.srcb = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero} !== 67'd0) begin
      miscompares++;
      $display("FAIL reset state: got hi=%h lo=%h busy=%b done=%b dz=%b want all 0",
               bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multiply();
    issue("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_result(0);
    vectors++;
    if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
      miscompares++; $display("FAIL multu_max const: got %h_%h want FFFFFFFE_00000001",
                              bus.hi, bus.lo);
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++; $display("FAIL done pulse width: got %b want 0", bus.done);
    end
    issue("mult_neg3x5", 2'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    wait_result(0);
    issue("mult_min_sq", 2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    wait_result(0);
  endtask

  task automatic test_divide();
    issue("div_neg7_2", 2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    wait_result(0);
    issue("divu_7_0", 2'd2, 32'd7, 32'd0, 1'b0, 1'b0);
    wait_result(0);
    issue("div_min_m1", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_result(0);
    issue("div_neg_0", 2'd3, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
    wait_result(0);
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] prev_hi;
    prev_hi = bus.hi;
    bus.lo_we = 1'b1; bus.wdata = 32'hAAAA_5555;
    @(negedge clk);
    bus.lo_we = 1'b0;
    vectors++;
    if (bus.lo !== 32'hAAAA_5555 || bus.hi !== prev_hi || bus.div_zero !== 1'b1) begin
      miscompares++; $display("FAIL mtlo: got hi=%h lo=%h dz=%b want %h/AAAA5555/1",
                              bus.hi, bus.lo, bus.div_zero, prev_hi);
    end
    issue("divu_sq", 2'd2, 32'd100, 32'd10, 1'b0, 1'b0);
    wait_result(0);
    bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    vectors++;
    if (bus.hi !== 32'h0000_1234 || bus.lo !== 32'd10 || bus.div_zero !== 1'b0) begin
      miscompares++; $display("FAIL mthi: got hi=%h lo=%h dz=%b want 00001234/0000000a/0",
                              bus.hi, bus.lo, bus.div_zero);
    end
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    vectors++;
    if (bus.hi !== 32'hCAFE_F00D || bus.lo !== 32'hCAFE_F00D) begin
      miscompares++; $display("FAIL mthi_mtlo both: got %h/%h want CAFEF00D/CAFEF00D",
                              bus.hi, bus.lo);
    end
    // start plus write in IDLE: the write must be dropped
    issue("start_wins", 2'd0, 32'd3, 32'd4, 1'b1, 1'b1);
    wait_result(0);
  endtask

  task automatic test_busy_ignore();
    logic [31:0] prev_hi;
    prev_hi = bus.hi;
    issue("divu_100_7", 2'd2, 32'd100, 32'd7, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.srca = 32'd5; bus.srcb = 32'd9;
    bus.hi_we = 1'b1; bus.wdata = 32'h5555_AAAA;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.hi !== prev_hi) begin
      miscompares++; $display("FAIL busy_ignore: got busy=%b hi=%h want 1/%h",
                              bus.busy, bus.hi, prev_hi);
    end
    wait_result(5);
  endtask

  task automatic test_back_to_back();
    issue("b2b_mult", 2'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_result(0);
    issue("b2b_div", 2'd3, 32'd1000, 32'hFFFF_FFF9, 1'b0, 1'b0);
    wait_result(0);
  endtask

  task automatic test_reset_midrun();
    exp_t dropped;
    issue("aborted", 2'd0, 32'd1234, 32'd5678, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      miscompares++; $display("FAIL reset_midrun: got busy=%b hi=%h lo=%h want 0/0/0",
                              bus.busy, bus.hi, bus.lo);
    end
    dropped = sb.pop_back();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue("multu_6x7", 2'd0, 32'd6, 32'd7, 1'b0, 1'b0);
    wait_result(0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [1:0]  op;
    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
      issue($sformatf("rand%0d", i), op, a, b, 1'b0, 1'b0);
      wait_result(0);
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_mthi_mtlo();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
